// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: PDU handshake capture into a power-of-two FIFO, drained by CPU MMIO loads.
// Define UART_RX_DROP_EN to discard (and count) bytes offered while full instead of backpressuring.
module uart_rx_fifo #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pdu_data_ready,
    input  logic [7:0]  pdu_data,
    output logic        pdu_data_accept,
    input  logic [31:0] cpu_dmem_addr,
    input  logic        cpu_dmem_re,
    output logic [31:0] cpu_dmem_rdata,
    output logic        rx_nonempty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_RX_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [7:0]      drop_cnt;

    logic full;
    logic empty;
    logic status_hit;
    logic data_hit;
    logic push;
    logic pop;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign status_hit = (cpu_dmem_addr == BASE_ADDR);
    assign data_hit   = (cpu_dmem_addr == BASE_ADDR + 32'd4);
    assign push       = (state == S_IDLE) && pdu_data_ready && !full;
    assign pop        = cpu_dmem_re && data_hit && !empty;
    assign rx_nonempty = !empty;

    // Accept is a registered Moore output, so ready never reaches it combinationally.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            pdu_data_accept <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pdu_data_ready && (!full || DROP_EN)) begin
                        state           <= S_ACK;
                        pdu_data_accept <= 1'b1;
                    end
                end
                S_ACK: begin
                    state           <= S_WAIT;
                    pdu_data_accept <= 1'b0;
                end
                S_WAIT: begin
                    if (!pdu_data_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state           <= S_IDLE;
                    pdu_data_accept <= 1'b0;
                end
            endcase
        end
    end

    // Pointers wrap naturally at AW bits because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable through count/rptr, which are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= pdu_data;
        end
    end

`ifdef UART_RX_DROP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 8'h00;
        end else if ((state == S_IDLE) && pdu_data_ready && full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`else
    assign drop_cnt = 8'h00;
`endif

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        cpu_dmem_rdata = 32'h0;
        if (status_hit) begin
            cpu_dmem_rdata = {8'h00, drop_cnt, 8'(count), 6'b0, full, !empty};
        end else if (data_hit) begin
            cpu_dmem_rdata = empty ? 32'hFFFF_FFFF : {24'h0, mem[rptr]};
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios pinned with literals, then randomized
// PDU/CPU traffic compared every cycle against a queue-based model of the buffer.
module tb_uart_rx_fifo;

    localparam int          DEPTH     = 16;
    localparam logic [31:0] BASE_ADDR = 32'hFFFF0010;
    localparam logic [31:0] STAT_A    = BASE_ADDR;
    localparam logic [31:0] DATA_A    = BASE_ADDR + 32'd4;

`ifdef UART_RX_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pdu_data_ready;
    logic [7:0]  pdu_data;
    logic        pdu_data_accept;
    logic [31:0] cpu_dmem_addr;
    logic        cpu_dmem_re;
    logic [31:0] cpu_dmem_rdata;
    logic        rx_nonempty;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: byte queue, handshake phase flags, drop counter.
    logic [7:0] m_q[$];
    bit         m_idle;
    bit         m_acc;
    int         m_drop;

    always #10 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pdu_data_ready (pdu_data_ready),
        .pdu_data       (pdu_data),
        .pdu_data_accept(pdu_data_accept),
        .cpu_dmem_addr  (cpu_dmem_addr),
        .cpu_dmem_re    (cpu_dmem_re),
        .cpu_dmem_rdata (cpu_dmem_rdata),
        .rx_nonempty    (rx_nonempty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_idle = 1'b1;
        m_acc  = 1'b0;
        m_drop = 0;
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [7:0] cnt8;
        logic       is_full;
        cnt8    = 8'(m_q.size());
        is_full = (m_q.size() == DEPTH);
        if (cpu_dmem_addr == STAT_A)
            return {8'h00, 8'(m_drop), cnt8, 6'b0, is_full, m_q.size() != 0};
        if (cpu_dmem_addr == DATA_A)
            return (m_q.size() == 0) ? 32'hFFFF_FFFF : {24'h0, m_q[0]};
        return 32'h0;
    endfunction

    task automatic compare_model();
        check("rdata", cpu_dmem_rdata, exp_rdata());
        check("rx_nonempty", {31'b0, rx_nonempty}, {31'b0, m_q.size() != 0});
        check("accept", {31'b0, pdu_data_accept}, {31'b0, m_acc});
    endtask

    // Advance the model across one clock edge using the inputs applied during that cycle.
    task automatic model_edge();
        bit do_pop;
        bit was_full;
        if (!rst) begin
            model_reset();
            return;
        end
        was_full = (m_q.size() == DEPTH);
        do_pop   = cpu_dmem_re && (cpu_dmem_addr == DATA_A) && (m_q.size() != 0);
        if (do_pop) void'(m_q.pop_front());
        if (m_idle) begin
            if (pdu_data_ready && (!was_full || DROP_EN)) begin
                if (!was_full) m_q.push_back(pdu_data);
                else if (m_drop < 255) m_drop++;
                m_idle = 1'b0;
                m_acc  = 1'b1;
            end
        end else if (m_acc) begin
            m_acc = 1'b0;
        end else if (!pdu_data_ready) begin
            m_idle = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [7:0] d,
                         input logic [31:0] a, input logic re);
        @(negedge clk);
        rst            = r;
        pdu_data_ready = rdy;
        pdu_data       = d;
        cpu_dmem_addr  = a;
        cpu_dmem_re    = re;
        if (!r) model_reset();
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic push_byte(input logic [7:0] b);
        drive(1'b1, 1'b1, b, STAT_A, 1'b0);
        tick();
        drive(1'b1, 1'b1, b, STAT_A, 1'b0);
        check("push_accept", {31'b0, pdu_data_accept}, 32'd1);
        tick();
        drive(1'b1, 1'b0, b, STAT_A, 1'b0);
        tick();
    endtask

    task automatic pop_expect(input string name, input logic [7:0] b);
        drive(1'b1, 1'b0, 8'h00, DATA_A, 1'b1);
        check(name, cpu_dmem_rdata, {24'h0, b});
        tick();
    endtask

    initial begin
        int          acc;
        logic        p_rdy;
        logic [7:0]  p_byte;
        bit          p_seen;
        int          p_linger;
        int          rd_pct;
        logic [31:0] a;
        logic        r;
        int          ar;

        rst = 1'b0; pdu_data_ready = 1'b0; pdu_data = 8'h00;
        cpu_dmem_addr = 32'h0; cpu_dmem_re = 1'b0;
        model_reset();

        // Reset state
        drive(1'b0, 1'b0, 8'h00, STAT_A, 1'b0);
        check("reset_status", cpu_dmem_rdata, 32'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, DATA_A, 1'b1);
        check("reset_data", cpu_dmem_rdata, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
        tick();

        // Reset asserted mid-ACK, ready held through reset: byte is recaptured
        drive(1'b1, 1'b1, 8'hC3, STAT_A, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'hC3, STAT_A, 1'b0);
        check("rst_ack_accept", {31'b0, pdu_data_accept}, 32'd0);
        check("rst_ack_status", cpu_dmem_rdata, 32'h0);
        tick();
        drive(1'b0, 1'b1, 8'hC3, DATA_A, 1'b1);
        check("rst_ack_data", cpu_dmem_rdata, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b1, 8'hC3, STAT_A, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'hC3, STAT_A, 1'b0);
        check("recapture_accept", {31'b0, pdu_data_accept}, 32'd1);
        check("recapture_status", cpu_dmem_rdata, 32'h0000_0101);
        tick();
        drive(1'b1, 1'b0, 8'hC3, STAT_A, 1'b0);
        tick();
        pop_expect("recapture_data", 8'hC3);

        // Single byte
        drive(1'b1, 1'b1, 8'h5A, STAT_A, 1'b0);
        check("single_pre", cpu_dmem_rdata, 32'h0);
        tick();
        drive(1'b1, 1'b1, 8'h5A, STAT_A, 1'b0);
        check("single_accept", {31'b0, pdu_data_accept}, 32'd1);
        check("single_status", cpu_dmem_rdata, 32'h0000_0101);
        tick();
        drive(1'b1, 1'b0, 8'h5A, STAT_A, 1'b0);
        check("single_accept_end", {31'b0, pdu_data_accept}, 32'd0);
        tick();
        pop_expect("single_data", 8'h5A);
        drive(1'b1, 1'b0, 8'h00, STAT_A, 1'b0);
        check("single_after", cpu_dmem_rdata, 32'h0);
        tick();

        // Sticky ready: held 5 cycles past accept
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 8'h33, STAT_A, 1'b0);
            acc += int'(pdu_data_accept);
            tick();
        end
        drive(1'b1, 1'b0, 8'h33, STAT_A, 1'b0);
        check("sticky_accepts", acc, 32'd1);
        check("sticky_status", cpu_dmem_rdata, 32'h0000_0101);
        tick();
        pop_expect("sticky_data", 8'h33);

        // Fill across the pointer wrap
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        drive(1'b1, 1'b0, 8'h00, STAT_A, 1'b0);
        check("full_status", cpu_dmem_rdata, 32'h0000_1003);
        tick();
        if (DROP_EN) begin
            for (int i = 0; i < 3; i++) push_byte(8'hEE);
            drive(1'b1, 1'b0, 8'h00, STAT_A, 1'b0);
            check("drop_status", cpu_dmem_rdata, 32'h0003_1003);
            tick();
            pop_expect("full_pop", 8'h00);
            push_byte(8'hA5);
        end else begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, 1'b1, 8'hA5, STAT_A, 1'b0);
                check("full_no_accept", {31'b0, pdu_data_accept}, 32'd0);
                tick();
            end
            drive(1'b1, 1'b1, 8'hA5, DATA_A, 1'b1);
            check("full_pop", cpu_dmem_rdata, 32'h0000_0000);
            tick();
            drive(1'b1, 1'b1, 8'hA5, STAT_A, 1'b0);
            check("after_pop_status", cpu_dmem_rdata, 32'h0000_0F01);
            tick();
            drive(1'b1, 1'b1, 8'hA5, STAT_A, 1'b0);
            check("late_accept", {31'b0, pdu_data_accept}, 32'd1);
            check("refull_status", cpu_dmem_rdata, 32'h0000_1003);
            tick();
            drive(1'b1, 1'b0, 8'hA5, STAT_A, 1'b0);
            tick();
        end
        for (int i = 1; i < 16; i++) pop_expect("drain", 8'(i));
        pop_expect("drain_last", 8'hA5);

        // Simultaneous capture and pop at count 3
        push_byte(8'h10);
        push_byte(8'h11);
        push_byte(8'h12);
        drive(1'b1, 1'b1, 8'h13, DATA_A, 1'b1);
        check("simul_pop", cpu_dmem_rdata, 32'h0000_0010);
        tick();
        drive(1'b1, 1'b1, 8'h13, STAT_A, 1'b0);
        check("simul_status", cpu_dmem_rdata[15:0], 32'h0000_0301);
        tick();
        drive(1'b1, 1'b0, 8'h13, STAT_A, 1'b0);
        tick();
        pop_expect("simul_d1", 8'h11);
        pop_expect("simul_d2", 8'h12);
        pop_expect("simul_d3", 8'h13);

        // Randomized traffic with occasional asynchronous resets
        p_rdy = 1'b0; p_byte = 8'h00; p_seen = 1'b0; p_linger = 0; rd_pct = 30;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 500 == 0) rd_pct = $urandom_range(5, 90);
            r = ($urandom_range(0, 299) != 0);
            if (!p_rdy) begin
                if ($urandom_range(0, 2) == 0) begin
                    p_rdy    = 1'b1;
                    p_byte   = 8'($urandom);
                    p_seen   = 1'b0;
                    p_linger = $urandom_range(0, 4);
                end
            end else if (p_seen) begin
                if (p_linger == 0) p_rdy = 1'b0;
                else p_linger--;
            end
            ar = $urandom_range(0, 9);
            if (ar < 4)       a = DATA_A;
            else if (ar < 7)  a = STAT_A;
            else if (ar == 7) a = BASE_ADDR + 32'd8;
            else if (ar == 8) a = BASE_ADDR - 32'd4;
            else              a = BASE_ADDR ^ 32'h0000_0100;
            drive(r, p_rdy, p_byte, a, ($urandom_range(0, 99) < rd_pct));
            if (pdu_data_accept === 1'b1) p_seen = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
